// File: rtl/spi_txn_scheduler_pkg.sv
// Shared types and default constants for the SPI transaction scheduler.
// Requester indices double as bit positions in every per-requester vector.
package spi_sched_pkg;

    localparam int NUM_REQ           = 3;
    localparam int DEF_SIZE_W        = 13;
    localparam int DEF_SVC_FLASH_R   = 40;
    localparam int DEF_SVC_FLASH_W   = 48;
    localparam int DEF_MPU_BITS      = 16;
    localparam int DEF_MPU_DATA_BITS = 8;
    localparam int DEF_SHREG_BITS    = 16;
    localparam int DEF_GAP_CYCLES    = 4;
    localparam int DEF_MAX_BITS      = 255;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACTIVE,
        GAP
    } sched_state_t;

    typedef enum logic [1:0] {
        REQ_FLASH = 2'd0,
        REQ_MPU   = 2'd1,
        REQ_SHREG = 2'd2
    } req_idx_t;

    // Folds a 0..5 sum back onto the three requester slots.
    function automatic req_idx_t rr_wrap(input logic [2:0] v);
        logic [2:0] w;
        w = (v >= 3'd3) ? (v - 3'd3) : v;
        return req_idx_t'(w[1:0]);
    endfunction

endpackage

// File: rtl/spi_txn_scheduler_if.sv
// Requester handshakes plus the chip-select/size/mode bundle toward the SPI master.
interface spi_txn_scheduler_if #(
    parameter int SIZE_W = 13
);
    logic              flash_req;
    logic              flash_nrw;
    logic [SIZE_W-1:0] flash_size;
    logic              flash_gnt;
    logic              flash_done;
    logic              flash_err;
    logic              mpu_req;
    logic              mpu_gnt;
    logic              mpu_done;
    logic              shreg_req;
    logic              shreg_gnt;
    logic              shreg_done;
    logic              cs_flash;
    logic              cs_shift_reg;
    logic              cs_mpu;
    logic [SIZE_W-1:0] data_size;
    logic              master_mode_nrw;
    logic              busy;

    modport master (
        input  flash_req, flash_nrw, flash_size, mpu_req, shreg_req,
        output flash_gnt, flash_done, flash_err, mpu_gnt, mpu_done,
               shreg_gnt, shreg_done, cs_flash, cs_shift_reg, cs_mpu,
               data_size, master_mode_nrw, busy
    );

    modport slave (
        output flash_req, flash_nrw, flash_size, mpu_req, shreg_req,
        input  flash_gnt, flash_done, flash_err, mpu_gnt, mpu_done,
               shreg_gnt, shreg_done, cs_flash, cs_shift_reg, cs_mpu,
               data_size, master_mode_nrw, busy
    );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Three-way round-robin: first request at or after ptr wins; next_ptr is the slot after it.
module spi_rr_arbiter
    import spi_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           ptr,
    output logic [NUM_REQ-1:0] gnt,
    output req_idx_t           next_ptr
);

    req_idx_t           cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = rr_wrap({1'b0, ptr} + 3'(gi));
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Scan from the farthest slot back so the slot nearest ptr overrides.
    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                gnt           = '0;
                gnt[cand[k]]  = 1'b1;
                next_ptr      = rr_wrap({1'b0, cand[k]} + 3'd1);
            end
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI master between flash, MPU and shift-register requesters:
// round-robin grant, chip-select held for the transaction length, then an idle gap.
module spi_txn_scheduler
    import spi_sched_pkg::*;
#(
    parameter int SIZE_W      = DEF_SIZE_W,
    parameter int SVC_FLASH_R = DEF_SVC_FLASH_R,
    parameter int SVC_FLASH_W = DEF_SVC_FLASH_W,
    parameter int MPU_BITS    = DEF_MPU_BITS,
    parameter int SHREG_BITS  = DEF_SHREG_BITS,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int MAX_BITS    = DEF_MAX_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    spi_txn_scheduler_if.master  bus
);

    localparam int         LEN_W    = SIZE_W + 1;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    sched_state_t       state_reg, state_next;
    req_idx_t           ptr_reg, ptr_next, arb_ptr;
    logic [NUM_REQ-1:0] req_vec, arb_gnt;
    logic [NUM_REQ-1:0] win_reg, win_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic [NUM_REQ-1:0] cs_reg, cs_next;
    logic               err_reg, err_next;
    logic               nrw_reg, nrw_next;
    logic               busy_reg, busy_next;
    logic [SIZE_W-1:0]  size_reg, size_next;
    logic [LEN_W-1:0]   hold_reg, hold_next;
    logic [3:0]         gap_reg, gap_next;
    logic [LEN_W-1:0]   txn_len;
    logic [SIZE_W-1:0]  grant_size;
    logic               grant_nrw;

    assign req_vec[REQ_FLASH] = bus.flash_req;
    assign req_vec[REQ_MPU]   = bus.mpu_req;
    assign req_vec[REQ_SHREG] = bus.shreg_req;

    spi_rr_arbiter u_arb (
        .req      (req_vec),
        .ptr      (ptr_reg),
        .gnt      (arb_gnt),
        .next_ptr (arb_ptr)
    );

    // Transaction length is one bit wider than the size field so overflow past MAX_BITS is visible.
    always_comb begin : len_calc
        grant_size = bus.flash_size;
        grant_nrw  = bus.flash_nrw;
        txn_len    = LEN_W'(SVC_FLASH_R) + {1'b0, bus.flash_size};
        if (win_reg[REQ_MPU]) begin
            grant_size = SIZE_W'(DEF_MPU_DATA_BITS);
            grant_nrw  = 1'b0;
            txn_len    = LEN_W'(MPU_BITS);
        end else if (win_reg[REQ_SHREG]) begin
            grant_size = '0;
            grant_nrw  = 1'b1;
            txn_len    = LEN_W'(SHREG_BITS);
        end else if (bus.flash_nrw) begin
            txn_len    = LEN_W'(SVC_FLASH_W) + {1'b0, bus.flash_size};
        end
    end

    always_comb begin : fsm_next
        state_next = state_reg;
        ptr_next   = ptr_reg;
        win_next   = win_reg;
        hold_next  = hold_reg;
        gap_next   = gap_reg;
        size_next  = size_reg;
        nrw_next   = nrw_reg;
        cs_next    = '0;
        gnt_next   = '0;
        done_next  = '0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    state_next = GRANT;
                    win_next   = arb_gnt;
                    gnt_next   = arb_gnt;
                    ptr_next   = arb_ptr;
                end
            end
            GRANT: begin
                size_next = grant_size;
                nrw_next  = grant_nrw;
                if (txn_len > LEN_W'(MAX_BITS)) begin
                    done_next  = win_reg;
                    err_next   = win_reg[REQ_FLASH];
                    gap_next   = GAP_LOAD;
                    state_next = GAP;
                end else begin
                    // L+1 down to 0 gives L+2 cycles of chip-select.
                    hold_next  = txn_len + LEN_W'(1);
                    cs_next    = win_reg;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (hold_reg == '0) begin
                    done_next  = win_reg;
                    gap_next   = GAP_LOAD;
                    state_next = GAP;
                end else begin
                    hold_next  = hold_reg - LEN_W'(1);
                    cs_next    = win_reg;
                end
            end
            GAP: begin
                if (gap_reg == '0) state_next = IDLE;
                else               gap_next   = gap_reg - 4'd1;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            ptr_reg   <= REQ_FLASH;
            win_reg   <= '0;
            hold_reg  <= '0;
            gap_reg   <= '0;
            size_reg  <= '0;
            nrw_reg   <= 1'b0;
            cs_reg    <= '0;
            gnt_reg   <= '0;
            done_reg  <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
            hold_reg  <= hold_next;
            gap_reg   <= gap_next;
            size_reg  <= size_next;
            nrw_reg   <= nrw_next;
            cs_reg    <= cs_next;
            gnt_reg   <= gnt_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
        end
    end

    assign bus.flash_gnt       = gnt_reg[REQ_FLASH];
    assign bus.mpu_gnt         = gnt_reg[REQ_MPU];
    assign bus.shreg_gnt       = gnt_reg[REQ_SHREG];
    assign bus.flash_done      = done_reg[REQ_FLASH];
    assign bus.mpu_done        = done_reg[REQ_MPU];
    assign bus.shreg_done      = done_reg[REQ_SHREG];
    assign bus.flash_err       = err_reg;
    assign bus.cs_flash        = cs_reg[REQ_FLASH];
    assign bus.cs_mpu          = cs_reg[REQ_MPU];
    assign bus.cs_shift_reg    = cs_reg[REQ_SHREG];
    assign bus.data_size       = size_reg;
    assign bus.master_mode_nrw = nrw_reg;
    assign bus.busy            = busy_reg;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler: hand-computed lengths, gaps and grant order.
module tb_spi_txn_scheduler;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    spi_txn_scheduler_if #(.SIZE_W(13)) bus ();

    spi_txn_scheduler dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    logic [2:0] cs_v, gnt_v, done_v;
    assign cs_v   = {bus.cs_shift_reg, bus.cs_mpu, bus.cs_flash};
    assign gnt_v  = {bus.shreg_gnt, bus.mpu_gnt, bus.flash_gnt};
    assign done_v = {bus.shreg_done, bus.mpu_done, bus.flash_done};

    // Negedge monitor: pulse lengths, low gaps, overlap, grant order.
    int          run_len [3];
    int          last_len[3];
    int          pulses  [3];
    int          low_run, min_low, max_low, overlap, done_bad, clash, size_bad;
    bit          have_pulse;
    logic [2:0]  cs_prev;
    logic [12:0] size_first;
    logic        mode_first;
    int          gnt_q[$];

    task automatic clear_log();
        gnt_q.delete();
        overlap    = 0;
        min_low    = 9999;
        max_low    = 0;
        done_bad   = 0;
        clash      = 0;
        size_bad   = 0;
        have_pulse = 1'b0;
        for (int i = 0; i < 3; i++) pulses[i] = 0;
    endtask

    initial begin
        cs_prev = '0;
        low_run = 0;
        for (int i = 0; i < 3; i++) begin
            run_len[i]  = 0;
            last_len[i] = 0;
        end
        clear_log();
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                cs_prev    = '0;
                have_pulse = 1'b0;
                low_run    = 0;
                for (int i = 0; i < 3; i++) run_len[i] = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (cs_v[i]) run_len[i]++;
                    else if (cs_prev[i]) begin
                        last_len[i] = run_len[i];
                        run_len[i]  = 0;
                        pulses[i]++;
                        if (!done_v[i]) done_bad++;
                    end
                    if (gnt_v[i]) gnt_q.push_back(i);
                    if (gnt_v[i] && done_v[i]) clash++;
                end
                if ($countones(cs_v) > 1) overlap++;
                if (cs_v == 3'b000) begin
                    if (cs_prev != 3'b000) begin
                        have_pulse = 1'b1;
                        low_run    = 0;
                    end
                    low_run++;
                end else if (cs_prev == 3'b000) begin
                    if (have_pulse) begin
                        if (low_run < min_low) min_low = low_run;
                        if (low_run > max_low) max_low = low_run;
                    end
                    size_first = bus.data_size;
                    mode_first = bus.master_mode_nrw;
                end else if (bus.data_size != size_first || bus.master_mode_nrw != mode_first) begin
                    size_bad++;
                end
                cs_prev = cs_v;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_done(input int idx, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            tick();
            if (done_v[idx]) seen = 1'b1;
        end
        chk_eq(tag, int'(seen), 1);
        $display("txn %s: requester %0d done at %0t", tag, idx, $time);
    endtask

    task automatic wait_gnt(input int idx, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            tick();
            if (gnt_v[idx]) seen = 1'b1;
        end
        chk_eq(tag, int'(seen), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
        chk_eq(tag, int'(bus.busy), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, p, grants, ndone;
        bit raise;
        int exp_order[4];

        rst_i          = 1'b1;
        bus.flash_req  = 1'b0;
        bus.flash_nrw  = 1'b0;
        bus.flash_size = '0;
        bus.mpu_req    = 1'b0;
        bus.shreg_req  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk_eq("rst_busy", int'(bus.busy), 0);
        chk_eq("rst_cs", int'(cs_v), 0);
        chk_eq("rst_gnt", int'(gnt_v), 0);
        chk_eq("rst_done", int'({done_v, bus.flash_err}), 0);
        chk_eq("rst_size", int'(bus.data_size), 0);
        chk_eq("rst_mode", int'(bus.master_mode_nrw), 0);
        rst_i = 1'b0;
        tick();

        // Flash read, size 8: L = 48, CS 50 cycles, 4 gap cycles
        bus.flash_nrw  = 1'b0;
        bus.flash_size = 13'd8;
        bus.flash_req  = 1'b1;
        tick();
        chk_eq("t1_gnt", int'(bus.flash_gnt), 1);
        bus.flash_req = 1'b0;
        tick();
        chk_eq("t1_gnt_pulse", int'(bus.flash_gnt), 0);
        chk_eq("t1_cs_on", int'(cs_v), 1);
        chk_eq("t1_size", int'(bus.data_size), 8);
        chk_eq("t1_mode", int'(bus.master_mode_nrw), 0);
        wait_done(0, "t1_flash_rd");
        chk_eq("t1_err", int'(bus.flash_err), 0);
        chk_eq("t1_cs_off", int'(cs_v), 0);
        g = 1;
        for (int n = 0; n < 20 && bus.busy; n++) begin
            tick();
            if (bus.busy) g++;
        end
        chk_eq("t1_gap", g, 4);
        chk_eq("t1_cs_len", last_len[0], 50);
        chk_eq("t1_done_fall", done_bad, 0);

        // Flash write, size 200: L = 248, CS 250 cycles
        bus.flash_nrw  = 1'b1;
        bus.flash_size = 13'd200;
        bus.flash_req  = 1'b1;
        tick();
        chk_eq("t2_gnt", int'(bus.flash_gnt), 1);
        bus.flash_req = 1'b0;
        tick();
        chk_eq("t2_size", int'(bus.data_size), 200);
        chk_eq("t2_mode", int'(bus.master_mode_nrw), 1);
        wait_done(0, "t2_flash_wr");
        wait_idle("t2_idle");
        chk_eq("t2_cs_len", last_len[0], 250);

        // Flash write, size 208: L = 256 overflows, error without CS
        p = pulses[0];
        bus.flash_size = 13'd208;
        bus.flash_req  = 1'b1;
        tick();
        chk_eq("t2e_gnt", int'(bus.flash_gnt), 1);
        bus.flash_req = 1'b0;
        tick();
        chk_eq("t2e_done", int'(bus.flash_done), 1);
        chk_eq("t2e_err", int'(bus.flash_err), 1);
        chk_eq("t2e_cs", int'(cs_v), 0);
        $display("txn t2e_flash_ovf: error pulse at %0t", $time);
        wait_idle("t2e_idle");
        chk_eq("t2e_no_pulse", pulses[0], p);

        // All three requesting from reset; flash re-raised during shreg
        rst_i          = 1'b1;
        bus.flash_nrw  = 1'b0;
        bus.flash_size = 13'd8;
        bus.flash_req  = 1'b1;
        bus.mpu_req    = 1'b1;
        bus.shreg_req  = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        clear_log();
        grants = 0;
        raise  = 1'b0;
        for (int n = 0; n < 1500 && grants < 4; n++) begin
            tick();
            if (bus.flash_gnt) begin bus.flash_req = 1'b0; grants++; end
            if (bus.mpu_gnt)   begin bus.mpu_req   = 1'b0; grants++; end
            if (bus.shreg_gnt) begin bus.shreg_req = 1'b0; grants++; raise = 1'b1; end
            else if (raise && bus.cs_shift_reg) begin bus.flash_req = 1'b1; raise = 1'b0; end
        end
        chk_eq("t3_grants", grants, 4);
        wait_done(0, "t3_flash_again");
        wait_idle("t3_idle");
        exp_order = '{0, 1, 2, 0};
        for (int i = 0; i < 4; i++)
            chk_eq($sformatf("t3_order%0d", i), (i < gnt_q.size()) ? gnt_q[i] : 99, exp_order[i]);
        chk_eq("t3_overlap", overlap, 0);
        chk_eq("t3_min_low", min_low, 6);
        chk_eq("t3_clash", clash, 0);
        chk_eq("t3_done_fall", done_bad, 0);

        // MPU alone, shreg raised mid-transaction
        clear_log();
        bus.mpu_req = 1'b1;
        tick();
        chk_eq("t4_mpu_gnt", int'(bus.mpu_gnt), 1);
        bus.mpu_req = 1'b0;
        tick();
        chk_eq("t4_cs_mpu", int'(cs_v), 2);
        chk_eq("t4_mpu_size", int'(bus.data_size), 8);
        chk_eq("t4_mpu_mode", int'(bus.master_mode_nrw), 0);
        repeat (5) tick();
        bus.shreg_req = 1'b1;
        wait_done(1, "t4_mpu");
        wait_gnt(2, "t4_shreg_gnt");
        bus.shreg_req = 1'b0;
        tick();
        chk_eq("t4_cs_shreg", int'(cs_v), 4);
        chk_eq("t4_shreg_size", int'(bus.data_size), 0);
        chk_eq("t4_shreg_mode", int'(bus.master_mode_nrw), 1);
        wait_done(2, "t4_shreg");
        wait_idle("t4_idle");
        chk_eq("t4_mpu_len", last_len[1], 18);
        chk_eq("t4_shreg_len", last_len[2], 18);
        chk_eq("t4_min_low", min_low, 6);
        chk_eq("t4_stable", size_bad, 0);

        // Reset in cycle 10 of a flash transaction with MPU pending
        bus.flash_nrw  = 1'b0;
        bus.flash_size = 13'd8;
        bus.flash_req  = 1'b1;
        tick();
        chk_eq("t5_flash_gnt", int'(bus.flash_gnt), 1);
        bus.flash_req = 1'b0;
        bus.mpu_req   = 1'b1;
        repeat (10) tick();
        chk_eq("t5_cs_before", int'(cs_v), 1);
        #3 rst_i = 1'b1;
        #1;
        chk_eq("t5_rst_cs", int'(cs_v), 0);
        chk_eq("t5_rst_busy", int'(bus.busy), 0);
        chk_eq("t5_rst_pulses", int'({gnt_v, done_v}), 0);
        $display("txn t5_flash: aborted by reset at %0t", $time);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk_eq("t5_mpu_first", int'(gnt_v), 2);

        // MPU held high: back-to-back with exactly GAP_CYCLES + 2 low cycles
        clear_log();
        ndone = 0;
        for (int n = 0; n < 600 && ndone < 3; n++) begin
            tick();
            if (bus.mpu_done) begin
                ndone++;
                $display("txn t6_mpu: burst %0d done at %0t", ndone, $time);
            end
        end
        bus.mpu_req = 1'b0;
        chk_eq("t6_dones", ndone, 3);
        wait_idle("t6_idle");
        chk_eq("t6_pulses", pulses[1], 3);
        chk_eq("t6_len", last_len[1], 18);
        chk_eq("t6_min_low", min_low, 6);
        chk_eq("t6_max_low", max_low, 6);
        chk_eq("t6_overlap", overlap, 0);
        chk_eq("t6_done_fall", done_bad, 0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
